sam_mem_arbiter: RTL and testbench
==================================

Name: sam_mem_arbiter

Overview:
Shares the single SAM memory port between two requesters. Requester F is the instruction-fetch path: PC to MAR, read only. Requester D is the operand path: MAR/MBR, read or write. The block runs the memory REQUEST/RW/WAIT handshake one transaction at a time and returns data and a done pulse to the winner. It sits between the SAM datapath/controller and the Memory model.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
TIMEOUT_CYCLES, 15, BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch request; level, held until f_done
f_addr  in  ADDR_W  fetch address; stable while f_req=1
f_rdata  out  DATA_W  fetch read data
f_done  out  1  one-cycle completion pulse for F
f_err  out  1  one-cycle timeout pulse for F (coincides with f_done)
d_req  in  1  data request; level, held until d_done
d_rw  in  1  1=read, 0=write
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  data read data
d_done  out  1  one-cycle completion pulse for D
d_err  out  1  one-cycle timeout pulse for D
mem_addr  out  ADDR_W  to Memory address bus
mem_req  out  1  to Memory REQUEST
mem_rw  out  1  to Memory RW; 1=read
mem_wdata  out  DATA_W  write data to Memory
mem_rdata  in  DATA_W  read data from Memory
mem_wait  in  1  Memory WAIT; 1=busy

Behaviour:
- Reset values:
  - All outputs are 0: mem_req, mem_rw, mem_addr, mem_wdata, f_rdata, d_rdata, done, err.
  - State=IDLE. last_grant=D, so F wins the first tie.
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: round-robin; grant the requester that did not win last; update last_grant.
  - On grant: latch addr, rw (F forces rw=1) and wdata into mem_* registers; go to ISSUE.
- ISSUE: mem_req=1; mem_wait is ignored, giving the memory one cycle to raise it; go to BUSY.
- BUSY:
  - mem_req stays 1.
  - When mem_wait=0 is sampled: on a read, capture mem_rdata into the winner's rdata; go to DONE.
- DONE:
  - mem_req=0; the winner's done=1 for exactly this cycle; go to IDLE.
  - The winner's rdata holds until its next read completes. Writes leave rdata unchanged.
- Latency: request sampled in IDLE at edge N gives done high in cycle N+3 at minimum (zero-wait memory); each extra BUSY cycle adds one.
- mem_addr, mem_rw and mem_wdata are stable from ISSUE through DONE. Requester inputs are not re-sampled after the grant.
- Requester drops req mid-transaction: the transaction still completes and done still pulses.
- req still high in the cycle after done: treated as a new request at arbitration in IDLE.
- Back-to-back throughput: one transaction every 4 cycles at minimum.
- rst_n low mid-transaction: immediate return to IDLE with mem_req=0; no done pulse. Requesters must reissue.
- f_err and d_err stay 0 unless MEM_TIMEOUT_EN is defined.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle while mem_wait=1.
  - When it reaches TIMEOUT_CYCLES, go to DONE. The winner's done=1 and err=1; the winner's rdata is forced to 0.
  - The counter width is clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter. BUSY waits indefinitely and err outputs are tied to 0.

Decomposition:
- Package sam_pkg:
  - ADDR_W/DATA_W defaults
  - RW_READ=1, RW_WRITE=0
  - state enum {IDLE, ISSUE, BUSY, DONE}
  - requester ID enum {REQ_F, REQ_D}
- One sub-module, sam_rr_arb2: combinational 2-way round-robin grant from (f_req, d_req, last_grant). The last_grant flop stays in the top.

Test Plan:
1. Fetch read, zero wait: f_req=1, f_addr=16'h0010, mem returns 16'h1234 with mem_wait=0 → mem_req high for 2 cycles, mem_rw=1, f_done in cycle 3, f_rdata=16'h1234.
2. Data write with 3 wait cycles: d_rw=0, d_addr=16'h0020, d_wdata=16'hBEEF → mem_wdata=16'hBEEF, mem_rw=0, d_done at cycle 6, d_rdata unchanged.
3. Simultaneous requests after reset: both held high for 3 transactions → grant order F, D, F; done pulses alternate, never both in one cycle.
4. Reset mid-BUSY: assert rst_n=0 during BUSY → mem_req=0 asynchronously, no done pulse. After release, a fresh f_req completes normally.
5. Requester drops f_req in ISSUE → transaction completes, f_done pulses once, FSM returns to IDLE with no extra grant.
6. With MEM_TIMEOUT_EN, mem_wait stuck at 1 → d_done=1 and d_err=1 after TIMEOUT_CYCLES=15 BUSY cycles, d_rdata=0. Without the macro: no done after 100 cycles.

Source files
------------

// File: rtl/sam_pkg.sv
// Shared types and defaults for the SAM memory-port arbiter.
package sam_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    function automatic req_id_e other_id(input req_id_e id);
        return (id == REQ_F) ? REQ_D : REQ_F;
    endfunction

endpackage

// File: rtl/sam_rr_arb2.sv
// Combinational two-way round-robin grant between fetch (F) and data (D).
// On a tie the requester that did not win last time is granted.
module sam_rr_arb2
    import sam_pkg::*;
(
    input  logic    f_req_i,
    input  logic    d_req_i,
    input  req_id_e last_grant_i,
    output logic    gnt_vld_c_o,
    output req_id_e gnt_id_c_o
);

    always_comb begin
        gnt_vld_c_o = f_req_i | d_req_i;
        gnt_id_c_o  = REQ_F;
        if (f_req_i && d_req_i) begin
            gnt_id_c_o = other_id(last_grant_i);
        end else if (d_req_i) begin
            gnt_id_c_o = REQ_D;
        end
    end

endmodule

// File: rtl/sam_mem_arbiter.sv
// Arbitrates the single SAM memory port between fetch and data requesters.
// Optional BUSY timeout abort is enabled by defining MEM_TIMEOUT_EN.
module sam_mem_arbiter
    import sam_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_done,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wait
);

    state_e            state_q, state_d;
    req_id_e           last_grant_q, last_grant_d;
    req_id_e           winner_q, winner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              f_done_q, f_done_d;
    logic              d_done_q, d_done_d;
    logic              gnt_vld_c;
    req_id_e           gnt_id_c;
    logic              timeout_c;
    logic              finish_c;

    sam_rr_arb2 u_arb (
        .f_req_i      (f_req),
        .d_req_i      (d_req),
        .last_grant_i (last_grant_q),
        .gnt_vld_c_o  (gnt_vld_c),
        .gnt_id_c_o   (gnt_id_c)
    );

    // BUSY ends on a ready memory or an expired timeout.
    assign finish_c = (state_q == BUSY) && (!mem_wait || timeout_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld_c) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (finish_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        mem_req_d    = mem_req_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        f_done_d     = 1'b0;
        d_done_d     = 1'b0;
        if (state_q == IDLE && gnt_vld_c) begin
            mem_req_d    = 1'b1;
            winner_d     = gnt_id_c;
            last_grant_d = gnt_id_c;
            if (gnt_id_c == REQ_F) begin
                mem_addr_d  = f_addr;
                mem_rw_d    = RW_READ;
                mem_wdata_d = '0;
            end else begin
                mem_addr_d  = d_addr;
                mem_rw_d    = d_rw ? RW_READ : RW_WRITE;
                mem_wdata_d = d_wdata;
            end
        end
        // Read data is captured on the same edge that launches DONE.
        if (finish_c) begin
            mem_req_d = 1'b0;
            if (winner_q == REQ_F) begin
                f_done_d = 1'b1;
                if (timeout_c)                   f_rdata_d = '0;
                else if (mem_rw_q == RW_READ)    f_rdata_d = mem_rdata;
            end else begin
                d_done_d = 1'b1;
                if (timeout_c)                   d_rdata_d = '0;
                else if (mem_rw_q == RW_READ)    d_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_D;
            winner_q     <= REQ_F;
            mem_req_q    <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            mem_req_q    <= mem_req_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
            f_done_q     <= f_done_d;
            d_done_q     <= d_done_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             f_err_q, f_err_d;
    logic             d_err_q, d_err_d;

    // Counter reaches TIMEOUT_CYCLES on the edge that aborts.
    assign timeout_c = (state_q == BUSY) && mem_wait &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d   = cnt_q;
        f_err_d = 1'b0;
        d_err_d = 1'b0;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == BUSY && mem_wait) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (timeout_c) begin
            f_err_d = (winner_q == REQ_F);
            d_err_d = (winner_q == REQ_D);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            f_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            f_err_q <= f_err_d;
            d_err_q <= d_err_d;
        end
    end

    assign f_err = f_err_q;
    assign d_err = d_err_q;
`else
    assign timeout_c = 1'b0;
    assign f_err     = 1'b0;
    assign d_err     = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_done    = f_done_q;
    assign d_done    = d_done_q;

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// Directed self-checking bench for sam_mem_arbiter; cycle c counts negedges
// after the negedge (c0) on which a request is presented.
module tb_sam_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [15:0] f_addr;
    logic [15:0] f_rdata;
    logic        f_done;
    logic        f_err;
    logic        d_req;
    logic        d_rw;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_rw;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_wait;

    int n_checks = 0;
    int n_errors = 0;

    sam_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_done    (f_done),
        .f_err     (f_err),
        .d_req     (d_req),
        .d_rw      (d_rw),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_wait  (mem_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n     = 1'b0;
        f_req     = 1'b0;
        f_addr    = '0;
        d_req     = 1'b0;
        d_rw      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_wait  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_rw, f_done, d_done, f_err, d_err} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_req, mem_rw, f_done, d_done, f_err, d_err});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h expected 0",
                     {mem_addr, mem_wdata, f_rdata, d_rdata});
        end
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0010; mem_rdata = 16'h1234; mem_wait = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_req !== (c == 1 || c == 2)) begin
                n_errors++;
                $display("FAIL fetch_mem_req c%0d: got %b expected %b", c, mem_req, (c == 1 || c == 2));
            end
            n_checks++;
            if (f_done !== (c == 3) || f_err !== 1'b0) begin
                n_errors++;
                $display("FAIL fetch_done c%0d: got done=%b err=%b expected done=%b err=0", c, f_done, f_err, (c == 3));
            end
            if (c <= 3) begin
                n_checks++;
                if (mem_rw !== 1'b1 || mem_addr !== 16'h0010) begin
                    n_errors++;
                    $display("FAIL fetch_bus c%0d: got rw=%b addr=%h expected rw=1 addr=0010", c, mem_rw, mem_addr);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (f_rdata !== 16'h1234) begin
                    n_errors++;
                    $display("FAIL fetch_rdata: got %h expected 1234", f_rdata);
                end
                f_req = 1'b0;
            end
        end
    endtask

    task automatic test_write_wait();
        @(negedge clk);
        d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h0020; d_wdata = 16'hBEEF;
        mem_wait = 1'b1; mem_rdata = 16'hDEAD;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_checks++;
            if (d_done !== (c == 6)) begin
                n_errors++;
                $display("FAIL write_done c%0d: got %b expected %b", c, d_done, (c == 6));
            end
            n_checks++;
            if (mem_req !== (c <= 5)) begin
                n_errors++;
                $display("FAIL write_mem_req c%0d: got %b expected %b", c, mem_req, (c <= 5));
            end
            if (c <= 6) begin
                n_checks++;
                if (mem_wdata !== 16'hBEEF || mem_rw !== 1'b0 || mem_addr !== 16'h0020) begin
                    n_errors++;
                    $display("FAIL write_bus c%0d: got wdata=%h rw=%b addr=%h expected BEEF 0 0020",
                             c, mem_wdata, mem_rw, mem_addr);
                end
            end
            if (c == 5) mem_wait = 1'b0;
            if (c == 6) begin
                n_checks++;
                if (d_rdata !== 16'h0000 || f_rdata !== 16'h1234) begin
                    n_errors++;
                    $display("FAIL write_rdata_hold: got d=%h f=%h expected d=0000 f=1234", d_rdata, f_rdata);
                end
                d_req = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        @(negedge clk);
        f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0100; d_addr = 16'h0200;
        d_rw = 1'b1; mem_wait = 1'b0; mem_rdata = 16'h5A5A;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            n_checks++;
            if (f_done !== (c == 3 || c == 11) || d_done !== (c == 7)) begin
                n_errors++;
                $display("FAIL rr_done c%0d: got f=%b d=%b expected f=%b d=%b",
                         c, f_done, d_done, (c == 3 || c == 11), (c == 7));
            end
            if (c == 1 || c == 9) begin
                n_checks++;
                if (mem_addr !== 16'h0100 || mem_rw !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rr_grant_f c%0d: got addr=%h rw=%b expected 0100 1", c, mem_addr, mem_rw);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (mem_addr !== 16'h0200) begin
                    n_errors++;
                    $display("FAIL rr_grant_d c%0d: got addr=%h expected 0200", c, mem_addr);
                end
            end
            if (c == 11) begin
                f_req = 1'b0; d_req = 1'b0;
            end
        end
        n_checks++;
        if (mem_req !== 1'b0 || f_rdata !== 16'h5A5A || d_rdata !== 16'h5A5A) begin
            n_errors++;
            $display("FAIL rr_end: got req=%b f=%h d=%h expected 0 5A5A 5A5A", mem_req, f_rdata, d_rdata);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0030; mem_wait = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_busy_pre: got mem_req=%b expected 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || f_done !== 1'b0 || f_rdata !== 16'h0000) begin
            n_errors++;
            $display("FAIL rst_busy_async: got req=%b done=%b rdata=%h expected 0 0 0000", mem_req, f_done, f_rdata);
        end
        f_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (f_done !== 1'b0 || mem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_busy_quiet c%0d: got done=%b req=%b expected 0 0", c, f_done, mem_req);
            end
        end
        mem_wait = 1'b0; f_req = 1'b1; f_addr = 16'h0044; mem_rdata = 16'h4444;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (f_done !== (c == 3)) begin
                n_errors++;
                $display("FAIL rst_busy_fresh c%0d: got done=%b expected %b", c, f_done, (c == 3));
            end
            if (c == 3) begin
                n_checks++;
                if (f_rdata !== 16'h4444) begin
                    n_errors++;
                    $display("FAIL rst_busy_rdata: got %h expected 4444", f_rdata);
                end
                f_req = 1'b0;
            end
        end
    endtask

    task automatic test_drop_req();
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0050; mem_rdata = 16'h7777; mem_wait = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (f_done !== (c == 3) || mem_req !== (c == 1 || c == 2)) begin
                n_errors++;
                $display("FAIL drop_req c%0d: got done=%b req=%b expected done=%b req=%b",
                         c, f_done, mem_req, (c == 3), (c == 1 || c == 2));
            end
            if (c == 1) f_req = 1'b0;
            if (c == 3) begin
                n_checks++;
                if (f_rdata !== 16'h7777) begin
                    n_errors++;
                    $display("FAIL drop_rdata: got %h expected 7777", f_rdata);
                end
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        d_req = 1'b1; d_rw = 1'b1; d_addr = 16'h0060; mem_rdata = 16'h9999; mem_wait = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                n_checks++;
                if (d_done !== 1'b1 || d_rdata !== 16'h9999) begin
                    n_errors++;
                    $display("FAIL to_preread: got done=%b rdata=%h expected 1 9999", d_done, d_rdata);
                end
                d_req = 1'b0;
            end
        end
        d_req = 1'b1; d_addr = 16'h0070; mem_rdata = 16'hABCD; mem_wait = 1'b1;
`ifdef MEM_TIMEOUT_EN
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            n_checks++;
            if (d_done !== (c == 17) || d_err !== (c == 17)) begin
                n_errors++;
                $display("FAIL to_done c%0d: got done=%b err=%b expected %b %b",
                         c, d_done, d_err, (c == 17), (c == 17));
            end
            if (c == 17) begin
                n_checks++;
                if (d_rdata !== 16'h0000) begin
                    n_errors++;
                    $display("FAIL to_rdata: got %h expected 0000", d_rdata);
                end
                d_req = 1'b0;
            end
        end
        mem_wait = 1'b0;
`else
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            n_checks++;
            if (d_done !== 1'b0 || d_err !== 1'b0) begin
                n_errors++;
                $display("FAIL to_nodone c%0d: got done=%b err=%b expected 0 0", c, d_done, d_err);
            end
        end
        n_checks++;
        if (mem_req !== 1'b1 || d_rdata !== 16'h9999) begin
            n_errors++;
            $display("FAIL to_stuck: got req=%b rdata=%h expected 1 9999", mem_req, d_rdata);
        end
        apply_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_write_wait();
        test_round_robin();
        test_reset_mid_busy();
        test_drop_req();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
